// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite responder backing NUM_REGS 32-bit control/status registers.
// Write and read channels are independent, one outstanding transaction each.
// Optional macro AXI4LITE_SLAVE_REGS_WR_PULSE_EN adds the wr_pulse output:
// a one-cycle strobe per register, raised the cycle after an in-range write commit.
//
// Handshake semantics: a beat transfers on a rising edge where VALID && READY.
// VALID, once raised, is held with stable payload until that edge. READY may
// depend on internal state but never on the same-channel VALID.
module axi4lite_slave_regs #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int NUM_REGS       = 8
) (
  input  logic                                A_CLK,
  input  logic                                A_RST,
  input  logic                                AW_VALID,
  output logic                                AW_READY,
  input  logic [AXI_ADDR_WIDTH-1:0]           AW_ADDR,
  input  logic [2:0]                          AW_PROT,
  input  logic                                W_VALID,
  output logic                                W_READY,
  input  logic [AXI_DATA_WIDTH-1:0]           W_DATA,
  input  logic [AXI_DATA_WIDTH/8-1:0]         W_STRB,
  output logic                                B_VALID,
  input  logic                                B_READY,
  output logic [1:0]                          B_RESP,
  input  logic                                AR_VALID,
  output logic                                AR_READY,
  input  logic [AXI_ADDR_WIDTH-1:0]           AR_ADDR,
  input  logic [2:0]                          AR_PROT,
  output logic                                R_VALID,
  input  logic                                R_READY,
  output logic [AXI_DATA_WIDTH-1:0]           R_DATA,
  output logic [1:0]                          R_RESP,
  output logic [NUM_REGS*AXI_DATA_WIDTH-1:0]  reg_out
`ifdef AXI4LITE_SLAVE_REGS_WR_PULSE_EN
  ,
  output logic [NUM_REGS-1:0]                 wr_pulse
`endif
);

  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_LIMIT = AXI_ADDR_WIDTH'(NUM_REGS * 4);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic { ST_W_IDLE, ST_W_RESP } wr_state_e;
  typedef enum logic { ST_R_IDLE, ST_R_DATA } rd_state_e;

  wr_state_e                  wr_state_q;
  rd_state_e                  rd_state_q;
  logic [AXI_DATA_WIDTH-1:0]  regs_q [NUM_REGS];
  logic                       aw_held_q;
  logic                       w_held_q;
  logic [AXI_ADDR_WIDTH-1:0]  aw_addr_q;
  logic [AXI_DATA_WIDTH-1:0]  w_data_q;
  logic [STRB_W-1:0]          w_strb_q;
  logic [1:0]                 b_resp_q;
  logic [1:0]                 r_resp_q;
  logic [AXI_DATA_WIDTH-1:0]  r_data_q;

  logic                       aw_hs;
  logic                       w_hs;
  logic                       ar_hs;
  logic                       wr_go;
  logic [AXI_ADDR_WIDTH-1:0]  wr_addr_d;
  logic [AXI_DATA_WIDTH-1:0]  wr_data_d;
  logic [STRB_W-1:0]          wr_strb_d;
  logic                       wr_in_range;
  logic [IDX_W-1:0]           wr_idx;
  logic                       rd_in_range;
  logic [IDX_W-1:0]           rd_idx;

  // Protection bits carry no meaning for this register bank.
  logic unused_prot;
  assign unused_prot = ^{AW_PROT, AR_PROT};

  // Valid flags are decoded straight from the registered FSM states.
  assign B_VALID  = (wr_state_q == ST_W_RESP);
  assign R_VALID  = (rd_state_q == ST_R_DATA);
  assign B_RESP   = b_resp_q;
  assign R_RESP   = r_resp_q;
  assign R_DATA   = r_data_q;

  assign AW_READY = !A_RST && !aw_held_q && !B_VALID;
  assign W_READY  = !A_RST && !w_held_q && !B_VALID;
  assign AR_READY = !A_RST && !R_VALID;

  assign aw_hs = AW_VALID && AW_READY;
  assign w_hs  = W_VALID && W_READY;
  assign ar_hs = AR_VALID && AR_READY;

  // A held beat takes priority; otherwise the live bus beat is its own partner.
  assign wr_addr_d   = aw_held_q ? aw_addr_q : AW_ADDR;
  assign wr_data_d   = w_held_q ? w_data_q : W_DATA;
  assign wr_strb_d   = w_held_q ? w_strb_q : W_STRB;
  assign wr_go       = (wr_state_q == ST_W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign wr_in_range = wr_addr_d < ADDR_LIMIT;
  assign wr_idx      = wr_addr_d[IDX_W+1:2];
  assign rd_in_range = AR_ADDR < ADDR_LIMIT;
  assign rd_idx      = AR_ADDR[IDX_W+1:2];

  // Write FSM: collect AW and W in any order, then present B until accepted.
  always_ff @(posedge A_CLK) begin
    if (A_RST) begin
      wr_state_q <= ST_W_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      b_resp_q   <= RESP_OKAY;
    end else begin
      case (wr_state_q)
        ST_W_IDLE: begin
          if (wr_go) begin
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            b_resp_q   <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
            wr_state_q <= ST_W_RESP;
          end else begin
            if (aw_hs) begin
              aw_held_q <= 1'b1;
              aw_addr_q <= AW_ADDR;
            end
            if (w_hs) begin
              w_held_q <= 1'b1;
              w_data_q <= W_DATA;
              w_strb_q <= W_STRB;
            end
          end
        end
        ST_W_RESP: begin
          if (B_READY) wr_state_q <= ST_W_IDLE;
        end
        default: wr_state_q <= ST_W_IDLE;
      endcase
    end
  end

  // Register bank: byte-strobed update on an in-range commit.
  always_ff @(posedge A_CLK) begin
    if (A_RST) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_go && wr_in_range) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (wr_strb_d[k]) regs_q[wr_idx][k*8 +: 8] <= wr_data_d[k*8 +: 8];
      end
    end
  end

  // Read FSM: capture data on AR handshake (pre-write value on a same-edge commit).
  always_ff @(posedge A_CLK) begin
    if (A_RST) begin
      rd_state_q <= ST_R_IDLE;
      r_data_q   <= '0;
      r_resp_q   <= RESP_OKAY;
    end else begin
      case (rd_state_q)
        ST_R_IDLE: begin
          if (ar_hs) begin
            r_data_q   <= rd_in_range ? regs_q[rd_idx] : '0;
            r_resp_q   <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
            rd_state_q <= ST_R_DATA;
          end
        end
        ST_R_DATA: begin
          if (R_READY) rd_state_q <= ST_R_IDLE;
        end
        default: rd_state_q <= ST_R_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[g*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = regs_q[g];
  end

`ifdef AXI4LITE_SLAVE_REGS_WR_PULSE_EN
  logic [NUM_REGS-1:0] wr_pulse_q;

  // One-hot strobe for the committed register, aligned with B_VALID rising.
  always_ff @(posedge A_CLK) begin
    if (A_RST) wr_pulse_q <= '0;
    else if (wr_go && wr_in_range) wr_pulse_q <= NUM_REGS'(1) << wr_idx;
    else wr_pulse_q <= '0;
  end

  assign wr_pulse = wr_pulse_q;
`endif

endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// Self-checking bench for axi4lite_slave_regs (default parameters).
// Build with AXI4LITE_SLAVE_REGS_WR_PULSE_EN defined to also cover wr_pulse.
module tb_axi4lite_slave_regs;

  localparam int NREGS    = 8;
  localparam int ADDR_LIM = NREGS * 4;

  logic              A_CLK;
  logic              A_RST;
  logic              AW_VALID, AW_READY;
  logic [31:0]       AW_ADDR;
  logic [2:0]        AW_PROT;
  logic              W_VALID, W_READY;
  logic [31:0]       W_DATA;
  logic [3:0]        W_STRB;
  logic              B_VALID, B_READY;
  logic [1:0]        B_RESP;
  logic              AR_VALID, AR_READY;
  logic [31:0]       AR_ADDR;
  logic [2:0]        AR_PROT;
  logic              R_VALID, R_READY;
  logic [31:0]       R_DATA;
  logic [1:0]        R_RESP;
  logic [NREGS*32-1:0] reg_out;
`ifdef AXI4LITE_SLAVE_REGS_WR_PULSE_EN
  logic [NREGS-1:0]  wr_pulse;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_regs [NREGS];
  logic [1:0]  b_exp_q [$];
  logic [33:0] r_exp_q [$];

  axi4lite_slave_regs #(
    .AXI_ADDR_WIDTH(32),
    .AXI_DATA_WIDTH(32),
    .NUM_REGS(NREGS)
  ) dut (
    .A_CLK(A_CLK), .A_RST(A_RST),
    .AW_VALID(AW_VALID), .AW_READY(AW_READY), .AW_ADDR(AW_ADDR), .AW_PROT(AW_PROT),
    .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA), .W_STRB(W_STRB),
    .B_VALID(B_VALID), .B_READY(B_READY), .B_RESP(B_RESP),
    .AR_VALID(AR_VALID), .AR_READY(AR_READY), .AR_ADDR(AR_ADDR), .AR_PROT(AR_PROT),
    .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .R_RESP(R_RESP),
    .reg_out(reg_out)
`ifdef AXI4LITE_SLAVE_REGS_WR_PULSE_EN
    ,
    .wr_pulse(wr_pulse)
`endif
  );

  // ---------------- clock / reset ----------------
  initial A_CLK = 1'b0;
  always #5 A_CLK = ~A_CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare each response on the negedge before its handshake edge.
  always @(negedge A_CLK) begin
    if (!A_RST && B_VALID && B_READY) begin
      if (b_exp_q.size() == 0) check("b_unexpected", 1, 0);
      else check("b_resp", B_RESP, b_exp_q.pop_front());
    end
    if (!A_RST && R_VALID && R_READY) begin
      if (r_exp_q.size() == 0) check("r_unexpected", 1, 0);
      else check("r_resp_data", {R_RESP, R_DATA}, r_exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge A_CLK);
    #1;
  endtask

  task automatic check_regs();
    for (int i = 0; i < NREGS; i++)
      check($sformatf("reg_out[%0d]", i), reg_out[i*32 +: 32], exp_regs[i]);
  endtask

  task automatic drain();
    int c = 0;
    while ((b_exp_q.size() != 0 || r_exp_q.size() != 0) && c < 50) begin
      tick();
      c++;
    end
    check("drain_timeout", b_exp_q.size() + r_exp_q.size(), 0);
  endtask

  // Write with independent AW/W start delays; checks B latency after last beat.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_delay, input int w_delay);
    bit aw_done, w_done, aw_fire, w_fire, in_rng;
    int c;
    logic [NREGS-1:0] exp_pulse;
    in_rng = (addr < ADDR_LIM);
    b_exp_q.push_back(in_rng ? 2'b00 : 2'b10);
    exp_pulse = '0;
    if (in_rng) begin
      exp_pulse[addr[4:2]] = 1'b1;
      for (int k = 0; k < 4; k++)
        if (strb[k]) exp_regs[addr[4:2]][k*8 +: 8] = data[k*8 +: 8];
    end
    AW_ADDR = addr; W_DATA = data; W_STRB = strb;
    AW_VALID = (aw_delay == 0);
    W_VALID  = (w_delay == 0);
    aw_done = 0; w_done = 0; c = 0;
    while (!(aw_done && w_done) && c < 50) begin
      @(negedge A_CLK);
      if (w_done) begin
        check("w_ready_while_held", W_READY, 0);
        check("b_before_aw", B_VALID, 0);
      end
      if (aw_done) begin
        check("aw_ready_while_held", AW_READY, 0);
        check("b_before_w", B_VALID, 0);
      end
      aw_fire = AW_VALID && AW_READY;
      w_fire  = W_VALID && W_READY;
      tick();
      c++;
      if (aw_fire) begin AW_VALID = 0; aw_done = 1; end
      if (w_fire)  begin W_VALID = 0;  w_done = 1;  end
      if (!aw_done && c >= aw_delay) AW_VALID = 1;
      if (!w_done && c >= w_delay)   W_VALID = 1;
    end
    AW_VALID = 0; W_VALID = 0;
    check("wr_hs_timeout", aw_done && w_done, 1);
    @(negedge A_CLK);
    check("b_latency", B_VALID, 1);
`ifdef AXI4LITE_SLAVE_REGS_WR_PULSE_EN
    check("wr_pulse", wr_pulse, exp_pulse);
    @(negedge A_CLK);
    check("wr_pulse_one_cycle", wr_pulse, 0);
`endif
  endtask

  task automatic do_read(input logic [31:0] addr);
    bit fired;
    int c;
    if (addr < ADDR_LIM) r_exp_q.push_back({2'b00, exp_regs[addr[4:2]]});
    else r_exp_q.push_back({2'b10, 32'h0});
    AR_ADDR = addr; AR_VALID = 1; fired = 0; c = 0;
    while (!fired && c < 50) begin
      @(negedge A_CLK);
      fired = AR_READY;
      tick();
      c++;
    end
    AR_VALID = 0;
    check("ar_hs_timeout", fired, 1);
    @(negedge A_CLK);
    check("r_latency", R_VALID, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    A_RST = 1; AW_VALID = 0; AW_ADDR = '0; AW_PROT = '0; W_VALID = 0; W_DATA = '0;
    W_STRB = '0; B_READY = 1; AR_VALID = 0; AR_ADDR = '0; AR_PROT = '0; R_READY = 1;
    for (int i = 0; i < NREGS; i++) exp_regs[i] = '0;
    repeat (3) tick();
    @(negedge A_CLK);
    check("rst_aw_ready", AW_READY, 0);
    check("rst_w_ready", W_READY, 0);
    check("rst_ar_ready", AR_READY, 0);
    check("rst_b_valid", B_VALID, 0);
    check("rst_r_valid", R_VALID, 0);
    check("rst_r_data", {R_RESP, B_RESP, R_DATA}, 0);
    check("rst_reg_out", |reg_out, 0);
    tick();
    A_RST = 0;

    // Same-cycle AW/W, then read back.
    do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0);
    drain();
    check_regs();
    do_read(32'h04);
    drain();

    // W three cycles ahead of AW over a fully-set register.
    do_write(32'h08, 32'hFFFFFFFF, 4'hF, 0, 0);
    drain();
    do_write(32'h08, 32'h11223344, 4'h5, 3, 0);
    drain();
    check("reg2_partial", reg_out[2*32 +: 32], 32'hFF22FF44);
    // AW ahead of W.
    do_write(32'h18, 32'h0BADF00D, 4'hC, 0, 2);
    drain();
    check_regs();

    // Out of range access.
    do_write(32'h40, 32'h12345678, 4'hF, 0, 0);
    drain();
    check_regs();
    do_read(32'h40);
    drain();

    // B back-pressure: response stable, no new write channel acceptance.
    B_READY = 0;
    do_write(32'h0C, 32'h55AA55AA, 4'hF, 0, 0);
    repeat (5) begin
      @(negedge A_CLK);
      check("b_stall_valid", B_VALID, 1);
      check("b_stall_resp", B_RESP, 2'b00);
      check("b_stall_aw_ready", AW_READY, 0);
      check("b_stall_w_ready", W_READY, 0);
    end
    tick();
    B_READY = 1;
    drain();

    // R back-pressure: data stable, no new AR acceptance.
    R_READY = 0;
    do_read(32'h0C);
    repeat (4) begin
      @(negedge A_CLK);
      check("r_stall_valid", R_VALID, 1);
      check("r_stall_data", {R_RESP, R_DATA}, {2'b00, 32'h55AA55AA});
      check("r_stall_ar_ready", AR_READY, 0);
    end
    tick();
    R_READY = 1;
    drain();

    // Write commit and AR to the same register on the same edge.
    r_exp_q.push_back({2'b00, exp_regs[5]});
    b_exp_q.push_back(2'b00);
    exp_regs[5] = 32'hA5A5A5A5;
    AW_ADDR = 32'h14; W_DATA = 32'hA5A5A5A5; W_STRB = 4'hF; AR_ADDR = 32'h14;
    AW_VALID = 1; W_VALID = 1; AR_VALID = 1;
    @(negedge A_CLK);
    check("same_edge_ready", {AW_READY, W_READY, AR_READY}, 3'b111);
    tick();
    AW_VALID = 0; W_VALID = 0; AR_VALID = 0;
    @(negedge A_CLK);
    check("same_edge_valids", {B_VALID, R_VALID}, 2'b11);
    drain();
    do_read(32'h14);
    drain();

    // Reset while a B response is pending.
    do_write(32'h00, 32'h00001234, 4'hF, 0, 0);
    drain();
    B_READY = 0;
    do_write(32'h04, 32'hCAFE0000, 4'hF, 0, 0);
    b_exp_q.delete();
    tick();
    A_RST = 1;
    @(negedge A_CLK);
    check("midrst_aw_ready", AW_READY, 0);
    check("midrst_w_ready", W_READY, 0);
    check("midrst_ar_ready", AR_READY, 0);
    tick();
    @(negedge A_CLK);
    check("midrst_b_valid", B_VALID, 0);
    check("midrst_reg_out", |reg_out, 0);
    for (int i = 0; i < NREGS; i++) exp_regs[i] = '0;
    tick();
    A_RST = 0;
    B_READY = 1;
    repeat (3) begin
      @(negedge A_CLK);
      check("post_rst_no_b", B_VALID, 0);
    end
    tick();
    do_write(32'h0C, 32'h00C0FFEE, 4'hF, 0, 0);
    drain();
    check_regs();

    // Randomised mix of in-range and out-of-range traffic.
    for (int n = 0; n < 16; n++) begin
      do_write(32'($urandom_range(0, 11)) * 4, $urandom, 4'($urandom_range(0, 15)),
               $urandom_range(0, 3), $urandom_range(0, 3));
      drain();
      do_read(32'($urandom_range(0, 11)) * 4);
      drain();
    end
    check_regs();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi4lite_slave_regs.md
Name: axi4lite_slave_regs

Overview:
AXI4-Lite responder (slave end) of the axi4lite interface, backing a bank of NUM_REGS memory-mapped 32-bit control/status registers.
- Sits behind the axi4lite slave modport. Flat ports carry the same signal names as the interface.
- Register contents are exported as a flat vector to the surrounding fabric logic.
- One outstanding write and one outstanding read at a time. Write and read channels run independently.

Parameters:
AXI_ADDR_WIDTH, 32, byte address width of AW_ADDR/AR_ADDR
AXI_DATA_WIDTH, 32, data width (only 32 supported; 4 strobe bits)
NUM_REGS, 8, number of registers (power of two, 2..256)

Ports:
A_CLK  in  1  clock, all logic on rising edge
A_RST  in  1  reset, synchronous, active-high
AW_VALID  in  1  write address valid
AW_READY  out  1  write address ready
AW_ADDR  in  AXI_ADDR_WIDTH  write byte address
AW_PROT  in  3  ignored
W_VALID  in  1  write data valid
W_READY  out  1  write data ready
W_DATA  in  AXI_DATA_WIDTH  write data
W_STRB  in  AXI_DATA_WIDTH/8  byte strobes
B_VALID  out  1  write response valid
B_READY  in  1  write response ready
B_RESP  out  2  00 OKAY, 10 SLVERR
AR_VALID  in  1  read address valid
AR_READY  out  1  read address ready
AR_ADDR  in  AXI_ADDR_WIDTH  read byte address
AR_PROT  in  3  ignored
R_VALID  out  1  read data valid
R_READY  in  1  read data ready
R_DATA  out  AXI_DATA_WIDTH  read data
R_RESP  out  2  00 OKAY, 10 SLVERR
reg_out  out  NUM_REGS*AXI_DATA_WIDTH  register contents; reg i at bits [32i+31:32i]

Behaviour:
Reset (A_RST high at an edge):
- All registers, B_VALID, R_VALID, R_DATA, B_RESP, R_RESP and internal held flags go to 0.
- AW_READY, W_READY and AR_READY are 0 while A_RST is high.
- Reset mid-transaction discards the transaction: no B/R response afterwards, no register update.

Address decode:
- idx = ADDR[log2(NUM_REGS)+1:2]. ADDR[1:0] ignored.
- Access is in range iff ADDR < NUM_REGS*4; otherwise the response is SLVERR.

Write path:
- States: W_IDLE (collecting AW/W), W_RESP (B_VALID=1).
- AW_READY = !A_RST && !aw_held && !B_VALID. W_READY = !A_RST && !w_held && !B_VALID.
- AW and W handshakes are accepted in either order or in the same cycle. Each captured beat is held in a register until its partner arrives.
- go = (aw_held or AW handshake) and (w_held or W handshake), in W_IDLE.
- At the edge where go is true:
  - if in range, reg[idx] byte k <= W_DATA byte k for each W_STRB[k]=1; unstrobed bytes are unchanged;
  - if out of range, no register changes;
  - B_RESP is set (OKAY or SLVERR), B_VALID <= 1, held flags clear, move to W_RESP.
- Latency: B_VALID rises the cycle after the last of AW/W handshakes.
- W_RESP: B_VALID and B_RESP stay stable until the B_READY handshake, then return to W_IDLE. No new AW/W is accepted in W_RESP.

Read path:
- States: R_IDLE, R_DATA.
- AR_READY = !A_RST && !R_VALID.
- On the AR handshake edge:
  - R_DATA <= reg[idx], or 0 if out of range;
  - R_RESP <= OKAY or SLVERR;
  - R_VALID <= 1.
- Latency: 1 cycle.
- R_DATA/R_RESP stay stable while R_VALID=1 && !R_READY. The R handshake clears R_VALID. A new AR is accepted only the cycle after R_VALID falls.

Simultaneous events:
- Write commit and AR handshake to the same register on the same edge: read returns the pre-write value.
- The write and read paths never stall each other.

reg_out: driven directly from the registers, so an update is visible the cycle after commit.

Optional Feature:
Macro AXI4LITE_SLAVE_REGS_WR_PULSE_EN.
- Defined: adds output port wr_pulse [NUM_REGS-1:0]. Bit idx is high for exactly one cycle, the cycle after an in-range write commit (aligned with B_VALID rising), even when W_STRB=0. Reset value 0.
- Undefined: port absent; no other behaviour change.

Test Plan:
- AW addr 0x04 and W 0xDEADBEEF, strb 0xF, same cycle; B_READY=1 -> B_VALID next cycle, B_RESP=00; reg_out reg1=0xDEADBEEF; AR 0x04 -> R_DATA 0xDEADBEEF, OKAY, 1-cycle latency.
- W beat 3 cycles before AW (addr 0x08, data 0x11223344, strb 0x5) over reg2=0xFFFFFFFF -> W_READY low while held; reg2=0xFF22FF44; B_VALID only after AW.
- AW 0x40 with NUM_REGS=8 -> B_RESP=10, no register changes; AR 0x40 -> R_RESP=10, R_DATA=0.
- B_READY held low 5 cycles -> B_VALID/B_RESP stable, AW_READY/W_READY low throughout; R_READY low 4 cycles -> R_DATA stable, AR_READY low.
- Write 0xA5A5A5A5 committing on the same edge as AR to the same reg (old 0x0) -> R_DATA=0x0; subsequent read -> 0xA5A5A5A5.
- Assert A_RST while B_VALID=1 and reg0=0x1234 -> next cycle B_VALID=0, reg_out all 0, READYs low during reset; with AXI4LITE_SLAVE_REGS_WR_PULSE_EN, write reg3 -> wr_pulse=0x08 for one cycle.
